// File: rtl/mux_nt1_pipe.sv
// N:1 multiplexer with a one-deep registered output slot, valid/ready on every channel,
// explicit-select or round-robin grant. Optional sticky select error under MUX_SEL_ERR_EN.
module mux_nt1_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N     = 4,
  parameter int unsigned SELW  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mode,
  input  logic [SELW-1:0]    sel,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SELW-1:0]    out_chan
`ifdef MUX_SEL_ERR_EN
  ,
  output logic               sel_err
`endif
);

  logic             slot_free;
  logic             sel_ok;
  logic             gnt_vld;
  logic [SELW-1:0]  gnt;
  logic [SELW-1:0]  rr_ptr;
  logic [WIDTH-1:0] gnt_data;
  logic             xfer;
  logic             hi_vld, lo_vld;
  logic [SELW-1:0]  hi_ch, lo_ch;

  assign slot_free = !out_valid || out_ready;
  assign sel_ok    = (32'(sel) < N);

  // Round-robin search split into two ascending scans: channels above rr_ptr win
  // first, otherwise the lowest valid channel at or below rr_ptr (the wrap).
  always_comb begin
    hi_vld = 1'b0;
    lo_vld = 1'b0;
    hi_ch  = '0;
    lo_ch  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (in_valid[k]) begin
        if (k > 32'(rr_ptr)) begin
          if (!hi_vld) begin
            hi_vld = 1'b1;
            hi_ch  = SELW'(k);
          end
        end else if (!lo_vld) begin
          lo_vld = 1'b1;
          lo_ch  = SELW'(k);
        end
      end
    end
  end

  always_comb begin
    gnt_vld = 1'b0;
    gnt     = '0;
    if (!mode) begin
      gnt_vld = sel_ok;
      gnt     = sel;
    end else if (hi_vld) begin
      gnt_vld = 1'b1;
      gnt     = hi_ch;
    end else if (lo_vld) begin
      gnt_vld = 1'b1;
      gnt     = lo_ch;
    end
  end

  always_comb begin
    in_ready = '0;
    gnt_data = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (gnt == SELW'(k)) begin
        in_ready[k] = rst_n && gnt_vld && slot_free;
        gnt_data    = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  assign xfer = |(in_valid & in_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      rr_ptr    <= SELW'(N - 1);
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= gnt_data;
      out_chan  <= gnt;
      if (mode) rr_ptr <= gnt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef MUX_SEL_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                sel_err <= 1'b0;
    else if (!mode && !sel_ok) sel_err <= 1'b1;
  end
`endif

endmodule
